al_logic_idelay_calib: RTL



---
 rtl/al_logic_io_pkg.sv | 28 ++
 rtl/al_logic_idelay_calib_if.sv | 30 +++
 rtl/al_logic_sample_checker.sv | 37 +++
 rtl/al_logic_idelay_calib.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/al_logic_io_pkg.sv
// Shared definitions for the input-delay calibration slice: FSM encoding,
// tap count and the default training setup.
package al_logic_io_pkg;

   localparam int         TAP_COUNT      = 32;
   localparam logic [1:0] DEF_PATTERN    = 2'b10;
   localparam int         DEF_SETTLE_CYC = 16;
   localparam int         DEF_SAMPLE_CYC = 64;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SET    = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_SAMPLE = 3'd3;
   localparam logic [2:0] ST_EVAL   = 3'd4;
   localparam logic [2:0] ST_CENTER = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_SET    = ST_SET,
      S_SETTLE = ST_SETTLE,
      S_SAMPLE = ST_SAMPLE,
      S_EVAL   = ST_EVAL,
      S_CENTER = ST_CENTER,
      S_DONE   = ST_DONE
   } state_t;

endpackage

// File: rtl/al_logic_idelay_calib_if.sv
// Sequencer/pin-side bundle of the calibration controller, plus the FSM state
// exposed for observation.
interface al_logic_idelay_calib_if #(parameter int TAP_W = 5);
   import al_logic_io_pkg::*;

   // start is a one-cycle request that is accepted only while busy=0 and the
   // FSM is idle; done is a one-cycle completion pulse, and results stay valid
   // until the next accepted start. There is no backpressure on either side.
   logic             start;
   logic             q1;
   logic             q2;
   logic [TAP_W-1:0] tap;
   logic             busy;
   logic             done;
   logic             fail;
   logic [TAP_W-1:0] win_start;
   logic [TAP_W-1:0] win_end;
   state_t           state;

   modport master (
      output start, q1, q2,
      input  tap, busy, done, fail, win_start, win_end, state
   );

   modport slave (
      input  start, q1, q2,
      output tap, busy, done, fail, win_start, win_end, state
   );

endinterface

// File: rtl/al_logic_sample_checker.sv
// Counts the sample phase of one tap and records whether any {q1,q2} sample
// differed from the training pattern.
module al_logic_sample_checker
   import al_logic_io_pkg::*;
#(
   parameter int         SAMPLE_CYC = DEF_SAMPLE_CYC,
   parameter logic [1:0] PATTERN    = DEF_PATTERN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic q1,
   input  logic q2,
   output logic cnt_done,
   output logic mismatch
);

   localparam int CW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q    <= '0;
         mismatch <= 1'b0;
      end else if (en) begin
         cnt_q <= cnt_q + CW'(1);
         if ({q1, q2} != PATTERN) mismatch <= 1'b1;
      end
   end

   // Asserted during the last sample cycle so the FSM leaves after exactly
   // SAMPLE_CYC samples; that final sample still lands in mismatch.
   assign cnt_done = en && (cnt_q == CW'(SAMPLE_CYC - 1));

endmodule

// File: rtl/al_logic_idelay_calib.sv
// Training-based tap sweep: scores every delay tap, tracks the longest passing
// window and parks the delay line at its centre.
module al_logic_idelay_calib
   import al_logic_io_pkg::*;
#(
   parameter int         TAP_W      = 5,
   parameter int         SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int         SAMPLE_CYC = DEF_SAMPLE_CYC,
   parameter logic [1:0] PATTERN    = DEF_PATTERN
) (
   input  logic                   clk,
   input  logic                   rst,
   al_logic_idelay_calib_if.slave bus
);

   localparam int LW = TAP_W + 1;
   localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   state_t           state_q, state_d;
   logic [TAP_W-1:0] cur_tap, tap_q, win_start_q, win_end_q;
   logic [TAP_W-1:0] run_start, run_start_d, best_start;
   logic [LW-1:0]    run_len, run_len_d, best_len;
   logic [SW-1:0]    settle_cnt;
   logic             fail_q, chk_clr, chk_en, chk_done, chk_mismatch;
   logic             settle_done, last_tap;

   assign settle_done = (settle_cnt == SW'(SETTLE_CYC - 1));
   assign last_tap    = &cur_tap;

   al_logic_sample_checker #(
      .SAMPLE_CYC (SAMPLE_CYC),
      .PATTERN    (PATTERN)
   ) u_checker (
      .clk      (clk),
      .rst      (rst),
      .clr      (chk_clr),
      .en       (chk_en),
      .q1       (bus.q1),
      .q2       (bus.q2),
      .cnt_done (chk_done),
      .mismatch (chk_mismatch)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      chk_clr = 1'b0;
      chk_en  = 1'b0;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_SET;
         S_SET: begin
            chk_clr = 1'b1;
            state_d = S_SETTLE;
         end
         S_SETTLE: if (settle_done) state_d = S_SAMPLE;
         S_SAMPLE: begin
            chk_en = 1'b1;
            if (chk_done) state_d = S_EVAL;
         end
         S_EVAL:   state_d = last_tap ? S_CENTER : S_SET;
         S_CENTER: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Run extension for the tap just scored; a failing tap breaks the run.
   always_comb begin
      run_len_d   = chk_mismatch ? '0 : run_len + LW'(1);
      run_start_d = (!chk_mismatch && run_len == '0) ? cur_tap : run_start;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_tap     <= '0;
         tap_q       <= '0;
         win_start_q <= '0;
         win_end_q   <= '0;
         run_start   <= '0;
         run_len     <= '0;
         best_start  <= '0;
         best_len    <= '0;
         settle_cnt  <= '0;
         fail_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  cur_tap    <= '0;
                  run_start  <= '0;
                  run_len    <= '0;
                  best_start <= '0;
                  best_len   <= '0;
                  fail_q     <= 1'b0;
               end
            end
            S_SET: begin
               tap_q      <= cur_tap;
               settle_cnt <= '0;
            end
            S_SETTLE: settle_cnt <= settle_cnt + SW'(1);
            S_EVAL: begin
               run_len   <= run_len_d;
               run_start <= run_start_d;
               // Strictly longer only, so on a tie the earlier window stays.
               if (run_len_d > best_len) begin
                  best_len   <= run_len_d;
                  best_start <= run_start_d;
               end
               if (!last_tap) cur_tap <= cur_tap + TAP_W'(1);
            end
            S_CENTER: begin
               if (best_len == '0) begin
                  tap_q       <= '0;
                  fail_q      <= 1'b1;
                  win_start_q <= '0;
                  win_end_q   <= '0;
               end else begin
                  win_start_q <= best_start;
                  win_end_q   <= best_start + TAP_W'(best_len - LW'(1));
                  tap_q       <= best_start + TAP_W'((best_len - LW'(1)) >> 1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.tap       = tap_q;
   assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.fail      = fail_q;
   assign bus.win_start = win_start_q;
   assign bus.win_end   = win_end_q;
   assign bus.state     = state_q;

endmodule
